// File: rtl/intel_fpga_apb2axil.sv
// APB4 completer to AXI4-Lite manager bridge: one APB transfer becomes one AXI-Lite
// read or write, with an optional response watchdog that aborts a stalled transaction.
module intel_fpga_apb2axil #(
    parameter int          P_ADDR_WIDTH      = 16,
    parameter int          P_DATA_WIDTH      = 32,
    parameter int          P_WATCHDOG_EN     = 1,
    parameter int          P_WATCHDOG_CYCLES = 1024,
    parameter logic [31:0] P_ERROR_DATA      = 32'h5D0C4610
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [P_ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic                      s_apb_psel,
    input  logic                      s_apb_penable,
    input  logic                      s_apb_pwrite,
    input  logic [P_DATA_WIDTH-1:0]   s_apb_pwdata,
    input  logic [P_DATA_WIDTH/8-1:0] s_apb_pstrb,
    input  logic [2:0]                s_apb_pprot,
    output logic [P_DATA_WIDTH-1:0]   s_apb_prdata,
    output logic                      s_apb_pready,
    output logic                      s_apb_pslverr,
    output logic [P_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [P_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [P_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [P_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [P_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int                WD_W    = $clog2(P_WATCHDOG_CYCLES);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(P_WATCHDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e                    state_q;
    logic [2:0]                rst_sync_q;
    logic [WD_W-1:0]           wdog_q;
    logic [P_ADDR_WIDTH-1:0]   addr_q;
    logic [P_DATA_WIDTH-1:0]   wdata_q;
    logic [P_DATA_WIDTH/8-1:0] wstrb_q;
    logic [2:0]                prot_q;
    logic                      pwrite_q;
    logic                      awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                      pready_q, pslverr_q;
    logic [P_DATA_WIDTH-1:0]   prdata_q;

    logic rst_n_s, start_s, active_s, resp_hit_s, abort_s, aw_ok_s, w_ok_s;

    assign rst_n_s    = rst_sync_q[2];
    assign start_s    = s_apb_psel & s_apb_penable & ~pready_q;
    assign active_s   = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                        (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
    assign resp_hit_s = ((state_q == S_WR_RESP) & m_axi_bvalid) |
                        ((state_q == S_RD_RESP) & m_axi_rvalid);
    // A response landing on the timeout cycle still wins over the abort.
    assign abort_s    = (P_WATCHDOG_EN != 0) && active_s && (wdog_q == WD_LAST) && !resp_hit_s;
    assign aw_ok_s    = ~awvalid_q | m_axi_awready;
    assign w_ok_s     = ~wvalid_q  | m_axi_wready;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = prot_q;
    assign m_axi_arprot  = prot_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign s_apb_prdata  = prdata_q;
    assign s_apb_pready  = pready_q;
    assign s_apb_pslverr = pslverr_q;

    // Reset release synchroniser: assert asynchronously, release on the third edge.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) rst_sync_q <= 3'b000;
        else                rst_sync_q <= {rst_sync_q[1:0], 1'b1};
    end

    // Watchdog: clear in IDLE, hold in DONE, count while a transaction is in flight.
    always_ff @(posedge s_axi_aclk or negedge rst_n_s) begin
        if (!rst_n_s)                              wdog_q <= '0;
        else if (state_q == S_IDLE)                wdog_q <= '0;
        else if (active_s && (P_WATCHDOG_EN != 0)) wdog_q <= wdog_q + WD_W'(1);
        else                                       wdog_q <= wdog_q;
    end

    // Transfer FSM with all handshake and APB outputs registered.
    always_ff @(posedge s_axi_aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            prot_q    <= 3'b000;
            pwrite_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else if (abort_s) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= pwrite_q ? '0 : P_ERROR_DATA;
            state_q   <= S_DONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Readies stay high here so a late response after an abort is drained.
                    bready_q <= 1'b1;
                    rready_q <= 1'b1;
                    if (start_s) begin
                        addr_q   <= s_apb_paddr;
                        wdata_q  <= s_apb_pwdata;
                        wstrb_q  <= s_apb_pstrb;
                        prot_q   <= s_apb_pprot;
                        pwrite_q <= s_apb_pwrite;
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        if (s_apb_pwrite) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if (aw_ok_s && w_ok_s) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q  <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= (m_axi_bresp != 2'b00);
                        prdata_q  <= '0;
                        state_q   <= S_DONE;
                    end
                end
                S_RD_REQ: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (m_axi_rvalid) begin
                        rready_q  <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= (m_axi_rresp != 2'b00);
                        prdata_q  <= m_axi_rdata;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    bready_q  <= 1'b1;
                    rready_q  <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                    pready_q  <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intel_fpga_apb2axil.sv
// Directed bench for the APB-to-AXI-Lite bridge: a vector table driven through an
// APB master plus a cycle-level AXI subordinate, then watchdog-drain and reset sequences.
module tb_intel_fpga_apb2axil;

    logic        clk, aresetn;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks   = 0;
    int failures = 0;
    int cur_vec  = 0;

    intel_fpga_apb2axil #(
        .P_ADDR_WIDTH(16), .P_DATA_WIDTH(32), .P_WATCHDOG_EN(1),
        .P_WATCHDOG_CYCLES(16), .P_ERROR_DATA(32'h5D0C4610)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
        .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_pprot(pprot), .s_apb_prdata(prdata), .s_apb_pready(pready),
        .s_apb_pslverr(pslverr),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    typedef struct {
        logic        pwrite;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          aw_d;
        int          w_d;
        int          ar_d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_prdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_vcyc;
        int          exp_wcyc;
        int          exp_hs;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, cur_vec, act, exp);
        end
    endtask

    // One APB transfer with the AXI subordinate modelled cycle by cycle.
    task automatic run_vec(input vec_t v);
        int aw_seen = 0, w_seen = 0, ar_seen = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, lat = 0;
        logic aw_acc = 1'b0, w_acc = 1'b0, ar_acc = 1'b0, rsp_sent = 1'b0;
        logic stable_ok = 1'b1, overlap = 1'b0, done = 1'b0, got_err = 1'b0;
        logic [31:0] got_prdata = 32'h0;
        psel = 1'b1; penable = 1'b0; pwrite = v.pwrite; paddr = v.addr;
        pwdata = v.wdata; pstrb = v.strb; pprot = v.prot;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(posedge clk); #1;
            if (awvalid && arvalid) overlap = 1'b1;
            if (pready) begin
                lat = cyc; got_prdata = prdata; got_err = pslverr; done = 1'b1;
            end
            if (bvalid) bvalid = 1'b0;
            else if (aw_acc && w_acc && !rsp_sent && bready) begin
                bvalid = 1'b1; bresp = v.resp; rsp_sent = 1'b1;
            end
            if (rvalid) rvalid = 1'b0;
            else if (ar_acc && !rsp_sent && rready) begin
                rvalid = 1'b1; rresp = v.resp; rdata = v.rdata; rsp_sent = 1'b1;
            end
            if (awvalid) begin
                aw_seen++;
                if (awaddr !== v.addr || awprot !== v.prot) stable_ok = 1'b0;
            end
            awready = awvalid && (aw_seen > v.aw_d);
            if (awready) begin aw_acc = 1'b1; aw_hs++; end
            if (wvalid) begin
                w_seen++;
                if (wdata !== v.wdata || wstrb !== v.strb) stable_ok = 1'b0;
            end
            wready = wvalid && (w_seen > v.w_d);
            if (wready) begin w_acc = 1'b1; w_hs++; end
            if (arvalid) begin
                ar_seen++;
                if (araddr !== v.addr || arprot !== v.prot) stable_ok = 1'b0;
            end
            arready = arvalid && (ar_seen > v.ar_d);
            if (arready) begin ar_acc = 1'b1; ar_hs++; end
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("prdata", got_prdata, v.exp_prdata);
        chk("pslverr", {31'h0, got_err}, {31'h0, v.exp_err});
        chk("addr_data_stable", {31'h0, stable_ok}, 32'h1);
        chk("aw_ar_overlap", {31'h0, overlap}, 32'h0);
        chk("valid_cycles", 32'(v.pwrite ? aw_seen : ar_seen), 32'(v.exp_vcyc));
        chk("wvalid_cycles", 32'(w_seen), 32'(v.exp_wcyc));
        chk("aw_handshakes", 32'(aw_hs), 32'(v.pwrite ? v.exp_hs : 0));
        chk("ar_handshakes", 32'(ar_hs), 32'(v.pwrite ? 0 : v.exp_hs));
        chk("w_handshakes", 32'(w_hs), 32'(v.pwrite ? 1 : 0));
        @(posedge clk); #1;
        chk("pready_one_cycle", {31'h0, pready}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    endtask

    initial begin
        //        wr    addr      wdata         strb  prot    aw w  ar   resp   rdata         prdata        err  lat vc wc hs
        vecs[0] = '{1'b1, 16'h0004, 32'hA5A51234, 4'hF, 3'b000, 0, 0, 0,   2'b00, 32'h00000000, 32'h00000000, 1'b0, 3, 1, 1, 1};
        vecs[1] = '{1'b0, 16'h0008, 32'h00000000, 4'h0, 3'b000, 0, 0, 5,   2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 8, 6, 0, 1};
        vecs[2] = '{1'b1, 16'h0010, 32'h11223344, 4'h3, 3'b010, 3, 0, 0,   2'b10, 32'h00000000, 32'h00000000, 1'b1, 6, 4, 1, 1};
        vecs[3] = '{1'b1, 16'h0014, 32'h89ABCDEF, 4'h8, 3'b101, 0, 2, 0,   2'b00, 32'h00000000, 32'h00000000, 1'b0, 5, 1, 3, 1};
        vecs[4] = '{1'b0, 16'h00FC, 32'h00000000, 4'h0, 3'b001, 0, 0, 0,   2'b11, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 3, 1, 0, 1};
        vecs[5] = '{1'b1, 16'hFFFC, 32'h00000001, 4'h1, 3'b111, 1, 1, 0,   2'b01, 32'h00000000, 32'h00000000, 1'b1, 4, 2, 2, 1};
        vecs[6] = '{1'b0, 16'h1234, 32'h00000000, 4'h0, 3'b100, 0, 0, 2,   2'b00, 32'h12345678, 32'h12345678, 1'b0, 5, 3, 0, 1};
        vecs[7] = '{1'b0, 16'h0020, 32'h00000000, 4'h0, 3'b000, 0, 0, 255, 2'b00, 32'h77777777, 32'h5D0C4610, 1'b1, 17, 16, 0, 0};

        aresetn = 1'b0; paddr = 16'h0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl_outputs", {25'h0, awvalid, wvalid, bready, arvalid, rready, pready, pslverr}, 32'h0);
        chk("reset_prdata", prdata, 32'h0);
        aresetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_readies", {30'h0, bready, rready}, 32'h3);

        for (int i = 0; i < 8; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
            @(posedge clk); #1;
        end

        // Late read data after the watchdog abort is drained in IDLE.
        cur_vec = 100;
        chk("late_rready_idle", {31'h0, rready}, 32'h1);
        rvalid = 1'b1; rdata = 32'hFFFFFFFF; rresp = 2'b10;
        @(posedge clk); #1;
        rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_resp_ignored", {28'h0, pready, pslverr, arvalid, awvalid}, 32'h0);
        cur_vec = 6;
        run_vec(vecs[6]);

        // Reset pulse while waiting for read data.
        cur_vec = 200;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0030; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("rst_seq_arvalid", {31'h0, arvalid}, 32'h1);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("rst_seq_rready_pre", {31'h0, rready}, 32'h1);
        #1;
        aresetn = 1'b0;
        #1;
        chk("rst_immediate_drop", {28'h0, rready, pready, arvalid, bready}, 32'h0);
        paddr = 16'h0040;
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        chk("rst_release_edge3_ignored", {31'h0, arvalid}, 32'h0);
        @(posedge clk); #1;
        chk("rst_release_edge4_start", {31'h0, arvalid}, 32'h1);
        chk("rst_release_araddr", {16'h0, araddr}, 32'h0040);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("rst_next_rready", {31'h0, rready}, 32'h1);
        rvalid = 1'b1; rdata = 32'hCAFE0001; rresp = 2'b00;
        @(posedge clk); #1;
        rvalid = 1'b0;
        chk("rst_next_pready", {31'h0, pready}, 32'h1);
        chk("rst_next_prdata", prdata, 32'hCAFE0001);
        chk("rst_next_pslverr", {31'h0, pslverr}, 32'h0);
        @(posedge clk); #1;
        chk("rst_next_pready_drop", {31'h0, pready}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
